fpumulp: RTL
============

# fpumulp

Parametrised, fully pipelined floating-point multiplier for the FPU datapath, generalising the fixed single-precision multiplier to configurable exponent/mantissa widths. Three-stage pipeline with valid/ready handshake, a tag field passed through for scheduler writeback, five IEEE-style rounding modes, and exception flags for every result. It sits in the FPU multiply slot and consumes and produces the codebase's extended-exponent register format.

## Interface
- EXP_W, 9: exponent width; bias = 2^(EXP_W-1)-1 (255 by default)
- MAN_W, 23: stored mantissa width, with an implicit leading 1
- TAG_W, 8: opaque tag width
- W (derived), EXP_W+MAN_W+1: operand width, 33 by default
- Operand layout: bit W-1 = exp[EXP_W-1]; bit W-2 = sign; bits W-3:MAN_W = exp[EXP_W-2:0]; bits MAN_W-1:0 = mantissa
- clk  in  1  clock; all registers update on negedge clk
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  pipeline accepts this cycle
- a, b  in  W  operands
- copy_a  in  1  pass `a` unchanged; no flags
- rmode  in  3  0 toward zero, 1 nearest ties-away, 2 nearest-even, 3 toward +inf, 4 toward -inf, 5-7 = 2
- tag_in  in  TAG_W  tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- res  out  W  result
- flags  out  4  [0] invalid, [1] overflow, [2] underflow, [3] inexact
- tag_out  out  TAG_W  tag of `res`
- flags_acc  out  4  sticky OR of delivered flags (see Configuration)
- flags_clr  in  1  clears flags_acc

## Operation
- Encoding: exp==0 is zero (no denormals); exp==2^EXP_W-2 is infinity; exp==2^EXP_W-1 is NaN.
- Specials take priority, in this order:
  - copy_a: res=a.
  - Inf×0: canonical qNaN (exp all ones, sign 0, mantissa MSB only), invalid=1.
  - Any NaN operand: canonical qNaN; invalid=1 if that NaN has mantissa MSB=0.
  - Inf×finite-nonzero or Inf×Inf: infinity carrying the product sign.
  - Zero×finite: signed zero.
- Sign is always a.sign ^ b.sign, except for copy_a and NaN results.
- S1: (MAN_W+1)×(MAN_W+1) product; exponent sum e = ea+eb-bias, signed, EXP_W+2 bits; special decode.
- S2: normalise. If product bit 2MAN_W+1 is set, shift right by one and e+1. Form guard bit and sticky bit. Compute round-up decision from rmode and sign.
- S3: add the round increment. A mantissa carry-out gives mantissa 0 and e+1. Then range-check and pack:
  - e ≥ 2^EXP_W-2: overflow=inexact=1. Infinity for modes 1/2, for mode 3 with a positive result, and for mode 4 with a negative result. Otherwise max finite (exp 2^EXP_W-3, mantissa all ones).
  - e ≤ 0: signed zero; underflow=inexact=1.
  - Otherwise inexact = guard|sticky.

## Timing
- Latency is 3 cycles from acceptance to out_valid when out_ready is held high; throughput is 1 per cycle.
- Each stage carries a valid bit. A stage loads when it is empty or when its contents advance this cycle. Holding registers do not change while stalled.
- in_ready = ~(all three stages valid & ~out_ready). This is combinational from out_ready.
- out_valid, res, flags and tag_out remain stable while out_valid & ~out_ready.
- Reset clears all stage valid bits. Outputs after reset: out_valid=0, res=0, flags=0, tag_out=0, flags_acc=0, in_ready=1. Any operation in flight when rst is asserted is discarded.
- flags_acc: on a transfer (out_valid & out_ready) it ORs in `flags`. flags_clr has priority, and the flags of a result delivered in the same cycle as flags_clr are lost.

## Configuration
- FPUMULP_FLAG_ACCUM_EN
  - Defined: flags_acc sticky register and flags_clr are implemented.
  - Undefined: flags_acc is tied to 0, flags_clr is ignored, and no register is built.

## Test plan
- a=33'h07FC00000 (1.5), b=1.5, rmode 2 → res 33'h100100000 (2.25), flags 0, out_valid exactly 3 cycles after acceptance, tag preserved.
- a=b=33'h07F800001, rmode 2 → 33'h07F800002, inexact=1. Same operands, rmode 3 → 33'h07F800003. Same operands, rmode 0 → 33'h07F800002.
- a=33'h17E800000, b=33'h100000000 (2.0):
  - rmode 2 → 33'h17F000000 (infinity), flags 4'b1010.
  - rmode 0 → 33'h17EFFFFFF, flags 4'b1010.
- a=b=33'h03F800000 (2^-128) → 33'h000000000, flags 4'b1100.
- Zero×infinity (33'h0 × 33'h17F000000) → 33'h17FC00000, invalid=1. copy_a=1 with a=33'h123456789 → res=a, flags 0.
- Stall and reset:
  - Issue 4 back-to-back operations with out_ready=0. in_ready must fall after 3 acceptances. The 4th operation is held and all 4 results then drain in order with no loss.
  - Asserting rst mid-stream gives out_valid=0 immediately and flags_acc=0.

Source files
------------

// File: rtl/fpumulp.sv
// fpumulp: three-stage pipelined floating-point multiplier on the extended-exponent register format.
// Define FPUMULP_FLAG_ACCUM_EN to build the sticky flags_acc register cleared by flags_clr.
module fpumulp #(
  parameter int EXP_W = 9,
  parameter int MAN_W = 23,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 copy_a,
  input  logic [2:0]           rmode,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] res,
  output logic [3:0]           flags,
  output logic [TAG_W-1:0]     tag_out,
  output logic [3:0]           flags_acc,
  input  logic                 flags_clr
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0]     EXP_INF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0]     EXP_MAX = {{(EXP_W-2){1'b1}}, 2'b01};
  localparam logic signed [EW-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EW-1:0] E_OVF   = {2'b00, EXP_INF};
  localparam logic [W-1:0]         QNAN    = {1'b1, 1'b0, {(EXP_W-1){1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [W-1:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                        input logic [MAN_W-1:0] m);
    return {e[EXP_W-1], s, e[EXP_W-2:0], m};
  endfunction

  function automatic logic round_up(input logic [2:0] rm, input logic s, input logic lsb,
                                    input logic g, input logic st);
    case (rm)
      3'd0:    round_up = 1'b0;
      3'd1:    round_up = g;
      3'd3:    round_up = ~s & (g | st);
      3'd4:    round_up = s & (g | st);
      default: round_up = g & (st | lsb);
    endcase
  endfunction

  function automatic logic ovf_to_inf(input logic [2:0] rm, input logic s);
    case (rm)
      3'd0:    ovf_to_inf = 1'b0;
      3'd3:    ovf_to_inf = ~s;
      3'd4:    ovf_to_inf = s;
      default: ovf_to_inf = 1'b1;
    endcase
  endfunction

  logic                 r_vld_p1, r_vld_p2, r_vld_p3;
  logic                 w_adv1, w_adv2, w_adv3;
  logic [EXP_W-1:0]     w_ea, w_eb;
  logic                 w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_sign, w_spec;
  logic [PW-1:0]        w_ma_x, w_mb_x, w_prod;
  logic signed [EW-1:0] w_esum;
  logic [W-1:0]         w_spec_res;
  logic [3:0]           w_spec_flg;

  // Handshake: each stage advances when the stage after it can take its contents
  assign w_adv3    = ~r_vld_p3 | out_ready;
  assign w_adv2    = ~r_vld_p2 | w_adv3;
  assign w_adv1    = ~r_vld_p1 | w_adv2;
  assign in_ready  = w_adv1;

  assign w_ea   = {a[W-1], a[W-3:MAN_W]};
  assign w_eb   = {b[W-1], b[W-3:MAN_W]};
  assign w_za   = (w_ea == '0);
  assign w_zb   = (w_eb == '0);
  assign w_ia   = (w_ea == EXP_INF);
  assign w_ib   = (w_eb == EXP_INF);
  assign w_na   = &w_ea;
  assign w_nb   = &w_eb;
  assign w_sign = a[W-2] ^ b[W-2];
  assign w_ma_x = {{(MAN_W+1){1'b0}}, 1'b1, a[MAN_W-1:0]};
  assign w_mb_x = {{(MAN_W+1){1'b0}}, 1'b1, b[MAN_W-1:0]};
  assign w_prod = w_ma_x * w_mb_x;
  assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = '0;
    w_spec_flg = '0;
    if (copy_a) begin
      w_spec_res = a;
    end else if ((w_ia & w_zb) | (w_za & w_ib)) begin
      w_spec_res = QNAN;
      w_spec_flg = 4'b0001;
    end else if (w_na | w_nb) begin
      w_spec_res    = QNAN;
      w_spec_flg[0] = (w_na & ~a[MAN_W-1]) | (w_nb & ~b[MAN_W-1]);
    end else if (w_ia | w_ib) begin
      w_spec_res = pack(w_sign, EXP_INF, '0);
    end else if (w_za | w_zb) begin
      w_spec_res = pack(w_sign, '0, '0);
    end else begin
      w_spec = 1'b0;
    end
  end

  // Stage 1: raw product, biased exponent sum, special-case result
  logic [PW-1:0]        r_prod_p1;
  logic signed [EW-1:0] r_e_p1;
  logic                 r_sign_p1, r_spec_p1;
  logic [W-1:0]         r_sres_p1;
  logic [3:0]           r_sflg_p1;
  logic [2:0]           r_rm_p1;
  logic [TAG_W-1:0]     r_tag_p1;

  always_ff @(negedge clk) begin
    if (w_adv1 && in_valid) begin
      r_prod_p1 <= w_prod;
      r_e_p1    <= w_esum;
      r_sign_p1 <= w_sign;
      r_spec_p1 <= w_spec;
      r_sres_p1 <= w_spec_res;
      r_sflg_p1 <= w_spec_flg;
      r_rm_p1   <= rmode;
      r_tag_p1  <= tag_in;
    end
  end

  logic                 w_hi, w_g2, w_st2;
  logic [MAN_W-1:0]     w_man2;
  logic signed [EW-1:0] w_e2;

  assign w_hi   = r_prod_p1[PW-1];
  assign w_man2 = w_hi ? r_prod_p1[PW-2 -: MAN_W] : r_prod_p1[PW-3 -: MAN_W];
  assign w_g2   = w_hi ? r_prod_p1[MAN_W] : r_prod_p1[MAN_W-1];
  assign w_st2  = w_hi ? |r_prod_p1[MAN_W-1:0] : |r_prod_p1[MAN_W-2:0];
  assign w_e2   = r_e_p1 + $signed({{(EW-1){1'b0}}, w_hi});

  // Stage 2: normalised mantissa, guard/sticky and the round-up decision
  logic [MAN_W-1:0]     r_man_p2;
  logic signed [EW-1:0] r_e_p2;
  logic                 r_g_p2, r_st_p2, r_up_p2, r_sign_p2, r_spec_p2;
  logic [W-1:0]         r_sres_p2;
  logic [3:0]           r_sflg_p2;
  logic [2:0]           r_rm_p2;
  logic [TAG_W-1:0]     r_tag_p2;

  always_ff @(negedge clk) begin
    if (w_adv2 && r_vld_p1) begin
      r_man_p2  <= w_man2;
      r_e_p2    <= w_e2;
      r_g_p2    <= w_g2;
      r_st_p2   <= w_st2;
      r_up_p2   <= round_up(r_rm_p1, r_sign_p1, w_man2[0], w_g2, w_st2);
      r_sign_p2 <= r_sign_p1;
      r_spec_p2 <= r_spec_p1;
      r_sres_p2 <= r_sres_p1;
      r_sflg_p2 <= r_sflg_p1;
      r_rm_p2   <= r_rm_p1;
      r_tag_p2  <= r_tag_p1;
    end
  end

  logic [MAN_W:0]       w_sum3;
  logic signed [EW-1:0] w_e3;
  logic [W-1:0]         w_res3;
  logic [3:0]           w_flg3;

  // A carry out of the mantissa leaves the low bits at zero, so only the exponent moves
  assign w_sum3 = {1'b0, r_man_p2} + {{MAN_W{1'b0}}, r_up_p2};
  assign w_e3   = r_e_p2 + $signed({{(EW-1){1'b0}}, w_sum3[MAN_W]});

  always_comb begin
    w_res3 = '0;
    w_flg3 = '0;
    if (r_spec_p2) begin
      w_res3 = r_sres_p2;
      w_flg3 = r_sflg_p2;
    end else if (w_e3 >= E_OVF) begin
      w_flg3 = 4'b1010;
      w_res3 = ovf_to_inf(r_rm_p2, r_sign_p2) ? pack(r_sign_p2, EXP_INF, '0)
                                              : pack(r_sign_p2, EXP_MAX, '1);
    end else if (w_e3[EW-1] || (w_e3 == '0)) begin
      w_flg3 = 4'b1100;
      w_res3 = pack(r_sign_p2, '0, '0);
    end else begin
      w_flg3 = {r_g_p2 | r_st_p2, 3'b000};
      w_res3 = pack(r_sign_p2, w_e3[EXP_W-1:0], w_sum3[MAN_W-1:0]);
    end
  end

  // Stage 3: packed result held at the output until the consumer takes it
  logic [W-1:0]     r_res_p3;
  logic [3:0]       r_flags_p3;
  logic [TAG_W-1:0] r_tag_p3;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_vld_p3   <= 1'b0;
      r_res_p3   <= '0;
      r_flags_p3 <= '0;
      r_tag_p3   <= '0;
    end else begin
      if (w_adv1) r_vld_p1 <= in_valid;
      if (w_adv2) r_vld_p2 <= r_vld_p1;
      if (w_adv3) begin
        r_vld_p3 <= r_vld_p2;
        if (r_vld_p2) begin
          r_res_p3   <= w_res3;
          r_flags_p3 <= w_flg3;
          r_tag_p3   <= r_tag_p2;
        end
      end
    end
  end

  assign out_valid = r_vld_p3;
  assign res       = r_res_p3;
  assign flags     = r_flags_p3;
  assign tag_out   = r_tag_p3;

`ifdef FPUMULP_FLAG_ACCUM_EN
  logic [3:0] r_flags_acc;

  always_ff @(negedge clk or posedge rst) begin
    if (rst)                        r_flags_acc <= '0;
    else if (flags_clr)             r_flags_acc <= '0;
    else if (r_vld_p3 && out_ready) r_flags_acc <= r_flags_acc | r_flags_p3;
  end

  assign flags_acc = r_flags_acc;
`else
  logic w_unused_clr;
  assign w_unused_clr = flags_clr;
  assign flags_acc    = '0;
`endif
endmodule
